// File: rtl/inv_skid_pkg.sv
// inv_skid_pkg: shared byte type, sizing constants and the inversion helper
package inv_skid_pkg;
    localparam int BYTE_W = 8;
    localparam int DEFAULT_DEPTH = 2;
    typedef logic [BYTE_W-1:0] byte_t;
    function automatic byte_t byte_invert(byte_t d, logic en);
        return en ? ~d : d;
    endfunction
endpackage

// File: rtl/inv_skid_fifo.sv
// inv_skid_fifo: DEPTH-entry synchronous circular FIFO with flush and occupancy
module inv_skid_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    // entry storage; a flushed push is harmless because the pointers reset
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr] <= din;
    end
    // pointers and occupancy; reset and flush both empty the buffer
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end
    assign full  = level == LW'(DEPTH);
    assign empty = level == '0;
    assign dout  = empty ? '0 : mem[rptr];
endmodule

// File: rtl/inv_byte_skid.sv
// inv_byte_skid: registered byte inverter with valid/ready buffering; INV_SKID_PARITY_EN adds out_parity
module inv_byte_skid
    import inv_skid_pkg::*;
#(
    parameter int DATA_W = BYTE_W,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       inv_en,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [CNT_W-1:0]           xfer_cnt,
    output logic [$clog2(DEPTH):0]     level
`ifdef INV_SKID_PARITY_EN
    ,
    output logic                       out_parity
`endif
);
`ifdef INV_SKID_PARITY_EN
    localparam int FW = DATA_W + 1;
`else
    localparam int FW = DATA_W;
`endif
    logic [FW-1:0] din, dout;
    logic push, pop, full, empty;
    byte_t stored;
    assign stored    = byte_invert(in_data, inv_en);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
`ifdef INV_SKID_PARITY_EN
    assign din        = {^stored, stored};
    assign out_parity = dout[DATA_W];
`else
    assign din = stored;
`endif
    assign out_data = dout[DATA_W-1:0];
    inv_skid_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
        .din(din), .dout(dout), .level(level), .full(full), .empty(empty)
    );
    // delivered-byte counter; flushed pops do not count and only reset clears it
    always_ff @(posedge clk) begin
        if (rst) xfer_cnt <= '0;
        else if (pop && !flush) xfer_cnt <= xfer_cnt + 1'b1;
    end
endmodule

// File: doc/inv_byte_skid.md
Name: inv_byte_skid

Overview:
- Registered, flow-controlled 8-bit bitwise-inversion stage.
- Accepts bytes on a valid/ready input stream, applies bitwise NOT (or passes through when inversion is disabled), buffers up to DEPTH results, and presents them on a valid/ready output stream.
- Sits directly upstream of the combinational 8-bit inverter consumers: gives them a registered, back-pressurable byte source instead of a raw wire.
- Keeps a wrapping count of delivered bytes.

Parameters:
- DATA_W, 8: byte width; only 8 is supported.
- DEPTH, 2: buffer entries; power of two, range 2..8.
- CNT_W, 16: width of the delivered-byte counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream byte valid.
- in_ready  output  1  stage can accept a byte this cycle.
- in_data  input  DATA_W  upstream byte.
- inv_en  input  1  when 1, store ~in_data; when 0, store in_data; sampled with each accepted byte.
- flush  input  1  synchronous buffer clear.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  head entry.
- xfer_cnt  output  CNT_W  output handshakes completed, wrapping.
- level  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On rst: level=0, out_valid=0, in_ready=1, out_data=0, xfer_cnt=0, pointers=0.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (level != DEPTH); it depends only on registered state, with no combinational path from out_ready.
- Storage: circular buffer with wrapping read and write pointers of $clog2(DEPTH) bits.
  - On push, entry[wptr] <= inv_en ? ~in_data : in_data.
- Output:
  - out_valid = (level != 0).
  - out_data = entry[rptr] when out_valid, else 0.
  - Data holds stable while out_valid & !out_ready.
- Latency: a byte pushed in cycle N is visible on out_data/out_valid in cycle N+1. The buffer never bypasses combinationally.
- Throughput: simultaneous push and pop with 0 < level < DEPTH leaves level unchanged, giving 1 byte/cycle sustained.
- Level update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on both or neither.
- Full: in_ready=0. A pop in the same cycle does not enable a push; the push happens the next cycle.
- Empty: out_valid=0. out_ready is ignored and xfer_cnt is unchanged.
- Counter: xfer_cnt increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- flush:
  - Next cycle: level=0, pointers=0, out_valid=0.
  - Overrides any push or pop in the same cycle; a byte offered that cycle is dropped.
  - The pop does not count, and xfer_cnt is preserved.
- Reset mid-transfer: everything is cleared as above, and buffered bytes are discarded.
- Priority: rst > flush > push/pop.

Optional Feature:
- Macro: INV_SKID_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = ^out_data of the head entry, stored per entry at push time.
  - out_parity is 0 when empty and 0 after reset.
- Undefined: the port and its storage are absent; all other behaviour is identical.

Decomposition:
- Shared package inv_skid_pkg holds:
  - constants BYTE_W=8 and DEFAULT_DEPTH=2;
  - typedef byte_t (logic [7:0]);
  - function byte_invert(byte_t d, logic en) returning en ? ~d : d, shared by RTL and the bench model.
- One natural sub-module, inv_skid_fifo: generic DEPTH-entry synchronous FIFO with push/pop/flush/level.
- The top adds inversion, the counter and the optional parity.

Test Plan:
- Reset, then idle: in_ready=1, out_valid=0, level=0, xfer_cnt=0, out_data=8'h00.
- Single byte: push 8'hFF with inv_en=1 and out_ready=0 → next cycle out_valid=1, out_data=8'h00. Then push 8'h00 with inv_en=1 → level=2, in_ready=0, head still 8'h00. Raise out_ready for two cycles → outputs 8'h00 then 8'hFF, xfer_cnt=2.
- Streaming: out_ready=1 and in_valid=1 for 256 cycles with in_data=0..255, inv_en=1 → outputs 8'hFF down to 8'h00 in order, one per cycle after 1-cycle latency, level never exceeds 1, xfer_cnt=256.
- Backpressure with full buffer: fill with 8'hA5 and 8'h3C (inv_en=0), hold out_ready=0 for 5 cycles while in_valid=1 → in_ready=0 throughout, no overwrite; drain yields 8'hA5, 8'h3C.
- flush with push and pop in the same cycle at level=2 → next cycle level=0, out_valid=0, xfer_cnt unchanged; the offered byte never appears.
- Wrap of xfer_cnt with CNT_W=4: 17 pops → xfer_cnt=1. With INV_SKID_PARITY_EN defined, push 8'h07 inv_en=0 → out_parity=1.
